// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
//
// ID/EX pipeline register with integrated load-use hazard detection.
//
// Each clock it captures the decoded operands, register indices and control
// bits of the instruction in ID, and presents them to EX and to the
// forwarding unit. If the instruction in ID reads a register that a load
// currently in EX is about to write, the PC and IF/ID are held for one cycle
// and a bubble (all-zero entry) is inserted here. A branch/jump redirect
// (Flush_i) also inserts a bubble. Bubbles caused by load-use stalls are
// counted in a saturating counter.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   Flush_i               squash the instruction entering ID/EX
//   ID_*                  decoded fields of the instruction in ID
//   ID_EX_*               registered copies of every ID_* field
//   Stall_o               load-use hazard: hold PC and IF/ID this cycle
//   PCWrite_o             PC write enable (inverse of Stall_o)
//   Bubble_Cnt_o          saturating count of stall bubbles
// ---------------------------------------------------------------------------
module id_ex_pipe_reg #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               Flush_i,

  input  logic [RADDR_W-1:0] ID_RS1,
  input  logic [RADDR_W-1:0] ID_RS2,
  input  logic               ID_UseRS1,
  input  logic               ID_UseRS2,
  input  logic [RADDR_W-1:0] ID_RD,
  input  logic [XLEN-1:0]    ID_RS1_Data,
  input  logic [XLEN-1:0]    ID_RS2_Data,
  input  logic [XLEN-1:0]    ID_Imm,
  input  logic [9:0]         ID_Funct,
  input  logic [1:0]         ID_ALUOp,
  input  logic               ID_ALUSrc,
  input  logic               ID_RegWrite,
  input  logic               ID_MemtoReg,
  input  logic               ID_MemRead,
  input  logic               ID_MemWrite,

  output logic [RADDR_W-1:0] ID_EX_RS1,
  output logic [RADDR_W-1:0] ID_EX_RS2,
  output logic               ID_EX_UseRS1,
  output logic               ID_EX_UseRS2,
  output logic [RADDR_W-1:0] ID_EX_RD,
  output logic [XLEN-1:0]    ID_EX_RS1_Data,
  output logic [XLEN-1:0]    ID_EX_RS2_Data,
  output logic [XLEN-1:0]    ID_EX_Imm,
  output logic [9:0]         ID_EX_Funct,
  output logic [1:0]         ID_EX_ALUOp,
  output logic               ID_EX_ALUSrc,
  output logic               ID_EX_RegWrite,
  output logic               ID_EX_MemtoReg,
  output logic               ID_EX_MemRead,
  output logic               ID_EX_MemWrite,

  output logic               Stall_o,
  output logic               PCWrite_o,
  output logic [CNT_W-1:0]   Bubble_Cnt_o
);

  // One pipeline entry. Keeping it as a struct lets a bubble be written as a
  // single '0 and keeps the load path to one assignment.
  typedef struct packed {
    logic [RADDR_W-1:0] rs1;
    logic [RADDR_W-1:0] rs2;
    logic               use_rs1;
    logic               use_rs2;
    logic [RADDR_W-1:0] rd;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [XLEN-1:0]    imm;
    logic [9:0]         funct;
    logic [1:0]         alu_op;
    logic               alu_src;
    logic               reg_write;
    logic               mem_to_reg;
    logic               mem_read;
    logic               mem_write;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  entry_t           id_entry;
  entry_t           ex_q;
  logic             rs1_hit;
  logic             rs2_hit;
  logic             stall;
  logic             bubble;
  logic [CNT_W-1:0] bubble_cnt_q;

  // Gather the ID-stage fields into one entry.
  always_comb begin
    id_entry            = '0;
    id_entry.rs1        = ID_RS1;
    id_entry.rs2        = ID_RS2;
    id_entry.use_rs1    = ID_UseRS1;
    id_entry.use_rs2    = ID_UseRS2;
    id_entry.rd         = ID_RD;
    id_entry.rs1_data   = ID_RS1_Data;
    id_entry.rs2_data   = ID_RS2_Data;
    id_entry.imm        = ID_Imm;
    id_entry.funct      = ID_Funct;
    id_entry.alu_op     = ID_ALUOp;
    id_entry.alu_src    = ID_ALUSrc;
    id_entry.reg_write  = ID_RegWrite;
    id_entry.mem_to_reg = ID_MemtoReg;
    id_entry.mem_read   = ID_MemRead;
    id_entry.mem_write  = ID_MemWrite;
  end

  // Load-use hazard. A load to x0 never produces a value, so it can never
  // cause a stall. Only sources the ID instruction really reads are compared.
  assign rs1_hit = ID_UseRS1 && (ex_q.rd == ID_RS1);
  assign rs2_hit = ID_UseRS2 && (ex_q.rd == ID_RS2);
  assign stall   = ex_q.mem_read && (ex_q.rd != '0) && (rs1_hit || rs2_hit);

  // A stall clears mem_read in the inserted bubble, so the hazard disappears
  // on its own after exactly one cycle and the held instruction then loads.
  assign bubble  = Flush_i || stall;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q <= '0;
    end else if (bubble) begin
      // Zeroing indices as well as control bits keeps the forwarding unit
      // from matching against a bubble.
      ex_q <= '0;
    end else begin
      ex_q <= id_entry;
    end
  end

  // Counts stall bubbles only (a flush coinciding with a stall still counts
  // once); holds at all-ones rather than wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bubble_cnt_q <= '0;
    end else if (stall && (bubble_cnt_q != CNT_MAX)) begin
      bubble_cnt_q <= bubble_cnt_q + 1'b1;
    end
  end

  assign ID_EX_RS1      = ex_q.rs1;
  assign ID_EX_RS2      = ex_q.rs2;
  assign ID_EX_UseRS1   = ex_q.use_rs1;
  assign ID_EX_UseRS2   = ex_q.use_rs2;
  assign ID_EX_RD       = ex_q.rd;
  assign ID_EX_RS1_Data = ex_q.rs1_data;
  assign ID_EX_RS2_Data = ex_q.rs2_data;
  assign ID_EX_Imm      = ex_q.imm;
  assign ID_EX_Funct    = ex_q.funct;
  assign ID_EX_ALUOp    = ex_q.alu_op;
  assign ID_EX_ALUSrc   = ex_q.alu_src;
  assign ID_EX_RegWrite = ex_q.reg_write;
  assign ID_EX_MemtoReg = ex_q.mem_to_reg;
  assign ID_EX_MemRead  = ex_q.mem_read;
  assign ID_EX_MemWrite = ex_q.mem_write;

  assign Stall_o        = stall;
  assign PCWrite_o      = !stall;
  assign Bubble_Cnt_o   = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_pipe_reg
//
// Directed bench for id_ex_pipe_reg with a 4-bit bubble counter so that
// saturation is reachable. Inputs change 1 ns after the rising edge; outputs
// are checked in that same window, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_id_ex_pipe_reg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  localparam int CNT_W   = 4;
  localparam int BUS_W   = 3*RADDR_W + 2 + 3*XLEN + 10 + 2 + 5;

  logic               clk_i;
  logic               rst_i;
  logic               Flush_i;
  logic [RADDR_W-1:0] ID_RS1, ID_RS2, ID_RD;
  logic               ID_UseRS1, ID_UseRS2;
  logic [XLEN-1:0]    ID_RS1_Data, ID_RS2_Data, ID_Imm;
  logic [9:0]         ID_Funct;
  logic [1:0]         ID_ALUOp;
  logic               ID_ALUSrc, ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite;

  logic [RADDR_W-1:0] ID_EX_RS1, ID_EX_RS2, ID_EX_RD;
  logic               ID_EX_UseRS1, ID_EX_UseRS2;
  logic [XLEN-1:0]    ID_EX_RS1_Data, ID_EX_RS2_Data, ID_EX_Imm;
  logic [9:0]         ID_EX_Funct;
  logic [1:0]         ID_EX_ALUOp;
  logic               ID_EX_ALUSrc, ID_EX_RegWrite, ID_EX_MemtoReg, ID_EX_MemRead, ID_EX_MemWrite;
  logic               Stall_o, PCWrite_o;
  logic [CNT_W-1:0]   Bubble_Cnt_o;

  int checks = 0;
  int errors = 0;

  logic [BUS_W-1:0] ex_bus;
  logic [BUS_W-1:0] exp_bus;

  id_ex_pipe_reg #(.XLEN(XLEN), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .Flush_i        (Flush_i),
    .ID_RS1         (ID_RS1),
    .ID_RS2         (ID_RS2),
    .ID_UseRS1      (ID_UseRS1),
    .ID_UseRS2      (ID_UseRS2),
    .ID_RD          (ID_RD),
    .ID_RS1_Data    (ID_RS1_Data),
    .ID_RS2_Data    (ID_RS2_Data),
    .ID_Imm         (ID_Imm),
    .ID_Funct       (ID_Funct),
    .ID_ALUOp       (ID_ALUOp),
    .ID_ALUSrc      (ID_ALUSrc),
    .ID_RegWrite    (ID_RegWrite),
    .ID_MemtoReg    (ID_MemtoReg),
    .ID_MemRead     (ID_MemRead),
    .ID_MemWrite    (ID_MemWrite),
    .ID_EX_RS1      (ID_EX_RS1),
    .ID_EX_RS2      (ID_EX_RS2),
    .ID_EX_UseRS1   (ID_EX_UseRS1),
    .ID_EX_UseRS2   (ID_EX_UseRS2),
    .ID_EX_RD       (ID_EX_RD),
    .ID_EX_RS1_Data (ID_EX_RS1_Data),
    .ID_EX_RS2_Data (ID_EX_RS2_Data),
    .ID_EX_Imm      (ID_EX_Imm),
    .ID_EX_Funct    (ID_EX_Funct),
    .ID_EX_ALUOp    (ID_EX_ALUOp),
    .ID_EX_ALUSrc   (ID_EX_ALUSrc),
    .ID_EX_RegWrite (ID_EX_RegWrite),
    .ID_EX_MemtoReg (ID_EX_MemtoReg),
    .ID_EX_MemRead  (ID_EX_MemRead),
    .ID_EX_MemWrite (ID_EX_MemWrite),
    .Stall_o        (Stall_o),
    .PCWrite_o      (PCWrite_o),
    .Bubble_Cnt_o   (Bubble_Cnt_o)
  );

  assign ex_bus = {ID_EX_RS1, ID_EX_RS2, ID_EX_UseRS1, ID_EX_UseRS2, ID_EX_RD,
                   ID_EX_RS1_Data, ID_EX_RS2_Data, ID_EX_Imm, ID_EX_Funct, ID_EX_ALUOp,
                   ID_EX_ALUSrc, ID_EX_RegWrite, ID_EX_MemtoReg, ID_EX_MemRead, ID_EX_MemWrite};

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [BUS_W-1:0] observed,
                       input logic [BUS_W-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_id();
    ID_RS1 = '0; ID_RS2 = '0; ID_RD = '0; ID_UseRS1 = 0; ID_UseRS2 = 0;
    ID_RS1_Data = '0; ID_RS2_Data = '0; ID_Imm = '0; ID_Funct = '0; ID_ALUOp = '0;
    ID_ALUSrc = 0; ID_RegWrite = 0; ID_MemtoReg = 0; ID_MemRead = 0; ID_MemWrite = 0;
  endtask

  // lw rd, imm(rs1)
  task automatic drive_load(input logic [RADDR_W-1:0] rd);
    clear_id();
    ID_RS1 = 5'd2; ID_UseRS1 = 1; ID_RD = rd; ID_RS1_Data = 32'h0000_1000;
    ID_Imm = 32'h0000_0008; ID_Funct = 10'h002; ID_ALUSrc = 1;
    ID_RegWrite = 1; ID_MemtoReg = 1; ID_MemRead = 1;
  endtask

  // add rd, rs1, rs2
  task automatic drive_add(input logic [RADDR_W-1:0] rs1, input logic use1,
                           input logic [RADDR_W-1:0] rs2, input logic use2,
                           input logic [RADDR_W-1:0] rd);
    clear_id();
    ID_RS1 = rs1; ID_UseRS1 = use1; ID_RS2 = rs2; ID_UseRS2 = use2; ID_RD = rd;
    ID_RS1_Data = 32'h1111_2222; ID_RS2_Data = 32'h3333_4444; ID_ALUOp = 2'b10;
    ID_RegWrite = 1;
  endtask

  initial begin
    rst_i = 1; Flush_i = 0;
    clear_id();

    // ---- 1: reset with random inputs ----
    ID_RS1 = RADDR_W'($urandom); ID_RS2 = RADDR_W'($urandom); ID_RD = RADDR_W'($urandom);
    ID_UseRS1 = 1; ID_UseRS2 = 1; ID_RS1_Data = $urandom; ID_RS2_Data = $urandom;
    ID_Imm = $urandom; ID_Funct = 10'($urandom); ID_ALUOp = 2'($urandom);
    ID_ALUSrc = 1; ID_RegWrite = 1; ID_MemtoReg = 1; ID_MemRead = 1; ID_MemWrite = 1;
    step();
    step();
    check("reset_bus", BUS_W'(ex_bus), '0);
    check("reset_stall", BUS_W'(Stall_o), BUS_W'(0));
    check("reset_pcwrite", BUS_W'(PCWrite_o), BUS_W'(1));
    check("reset_cnt", BUS_W'(Bubble_Cnt_o), BUS_W'(0));

    // ---- 2: pass-through ----
    rst_i = 0;
    clear_id();
    ID_RS1 = 5'd3; ID_RS2 = 5'd4; ID_RD = 5'd5; ID_RegWrite = 1; ID_Imm = 32'h0000_0010;
    ID_RS1_Data = 32'hDEAD_BEEF; ID_RS2_Data = 32'hCAFE_F00D; ID_Funct = 10'h155;
    ID_ALUOp = 2'b11; ID_ALUSrc = 1; ID_MemWrite = 1; ID_UseRS1 = 1;
    exp_bus = {5'd3, 5'd4, 1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_0010,
               10'h155, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    step();
    check("pass_bus", BUS_W'(ex_bus), exp_bus);
    check("pass_rd", BUS_W'(ID_EX_RD), BUS_W'(5));
    check("pass_imm", BUS_W'(ID_EX_Imm), BUS_W'(32'h10));
    check("pass_stall", BUS_W'(Stall_o), BUS_W'(0));

    // ---- 3: load-use stall ----
    drive_load(5'd5);
    step();
    check("lw_memread", BUS_W'(ID_EX_MemRead), BUS_W'(1));
    drive_add(5'd5, 1'b1, 5'd6, 1'b1, 5'd7);
    #1;
    check("lu_stall", BUS_W'(Stall_o), BUS_W'(1));
    check("lu_pcwrite", BUS_W'(PCWrite_o), BUS_W'(0));
    step();
    check("lu_bubble", BUS_W'(ex_bus), '0);
    check("lu_cnt", BUS_W'(Bubble_Cnt_o), BUS_W'(1));
    check("lu_stall_gone", BUS_W'(Stall_o), BUS_W'(0));
    check("lu_pcwrite_back", BUS_W'(PCWrite_o), BUS_W'(1));
    step();
    check("lu_add_rs1", BUS_W'(ID_EX_RS1), BUS_W'(5));
    check("lu_add_rd", BUS_W'(ID_EX_RD), BUS_W'(7));
    check("lu_add_regwrite", BUS_W'(ID_EX_RegWrite), BUS_W'(1));
    check("lu_add_nostall", BUS_W'(Stall_o), BUS_W'(0));

    // ---- 4: no false stalls ----
    drive_load(5'd5);
    step();
    drive_add(5'd1, 1'b1, 5'd5, 1'b0, 5'd8);
    #1;
    check("nouse_rs2_stall", BUS_W'(Stall_o), BUS_W'(0));
    step();
    drive_load(5'd0);
    step();
    drive_add(5'd0, 1'b1, 5'd0, 1'b1, 5'd9);
    #1;
    check("lw_x0_stall", BUS_W'(Stall_o), BUS_W'(0));
    step();
    check("lw_x0_cnt", BUS_W'(Bubble_Cnt_o), BUS_W'(1));

    // ---- 5: flush ----
    drive_add(5'd3, 1'b1, 5'd4, 1'b1, 5'd7);
    ID_Imm = 32'h0000_0ABC; ID_MemWrite = 1;
    Flush_i = 1;
    step();
    Flush_i = 0;
    check("flush_regwrite", BUS_W'(ID_EX_RegWrite), BUS_W'(0));
    check("flush_rd", BUS_W'(ID_EX_RD), BUS_W'(0));
    check("flush_bus", BUS_W'(ex_bus), '0);
    check("flush_cnt", BUS_W'(Bubble_Cnt_o), BUS_W'(1));

    drive_load(5'd5);
    step();
    drive_add(5'd5, 1'b1, 5'd0, 1'b0, 5'd10);
    Flush_i = 1;
    #1;
    check("flush_haz_stall", BUS_W'(Stall_o), BUS_W'(1));
    check("flush_haz_pcwrite", BUS_W'(PCWrite_o), BUS_W'(0));
    step();
    Flush_i = 0;
    check("flush_haz_bus", BUS_W'(ex_bus), '0);
    check("flush_haz_cnt", BUS_W'(Bubble_Cnt_o), BUS_W'(2));

    // ---- 6: saturation, then reset mid-stall ----
    for (int i = 0; i < 17; i++) begin
      drive_load(5'd5);
      step();
      drive_add(5'd0, 1'b0, 5'd5, 1'b1, 5'd11);
      step();
      if (i == 12) check("sat_cnt_reach", BUS_W'(Bubble_Cnt_o), BUS_W'(4'hF));
    end
    check("sat_cnt_hold", BUS_W'(Bubble_Cnt_o), BUS_W'(4'hF));

    drive_load(5'd5);
    step();
    drive_add(5'd5, 1'b1, 5'd0, 1'b0, 5'd12);
    #1;
    check("mid_stall_stall", BUS_W'(Stall_o), BUS_W'(1));
    rst_i = 1;
    step();
    check("mid_rst_cnt", BUS_W'(Bubble_Cnt_o), BUS_W'(0));
    check("mid_rst_stall", BUS_W'(Stall_o), BUS_W'(0));
    check("mid_rst_pcwrite", BUS_W'(PCWrite_o), BUS_W'(1));
    check("mid_rst_bus", BUS_W'(ex_bus), '0);
    rst_i = 0;
    step();
    check("post_rst_load_rs1", BUS_W'(ID_EX_RS1), BUS_W'(5));
    check("post_rst_load_rd", BUS_W'(ID_EX_RD), BUS_W'(12));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
